// File: rtl/stream_buffer_ring_writer_ctrl.sv
// Per-channel ring-buffer slot allocator for card-memory stream writers: offers slots over
// cfg, forwards write-completion notifications to the consumer link, reclaims on release.
module stream_buffer_ring_writer_ctrl #(
  parameter int unsigned     NUM_CH        = 4,
  parameter int unsigned     TRANSFER_SIZE = 64,
  parameter int unsigned     ALLOC_BYTES   = 65536,
  parameter int unsigned     RING_BYTES    = 1048576,
  parameter longint unsigned BASE_VADDR    = 0,
  parameter bit              LAST_NEW_SLOT = 1'b0,
  parameter int unsigned     VADDR_W       = 48,
  parameter int unsigned     SIZE_W        = 28,
  localparam int unsigned    SLOTS         = RING_BYTES / ALLOC_BYTES,
  localparam int unsigned    USED_W        = $clog2(SLOTS) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          notify_valid,
  output logic [NUM_CH-1:0]          notify_ready,
  input  logic [NUM_CH*SIZE_W-1:0]   notify_size,
  input  logic [NUM_CH-1:0]          notify_last,
  output logic [NUM_CH-1:0]          cfg_valid,
  input  logic [NUM_CH-1:0]          cfg_ready,
  output logic [NUM_CH*VADDR_W-1:0]  cfg_vaddr,
  output logic [NUM_CH*32-1:0]       cfg_size,
  output logic [NUM_CH-1:0]          link_valid,
  input  logic [NUM_CH-1:0]          link_ready,
  output logic [NUM_CH*VADDR_W-1:0]  link_vaddr,
  output logic [NUM_CH*SIZE_W-1:0]   link_size,
  output logic [NUM_CH-1:0]          link_last,
  input  logic [NUM_CH-1:0]          release_valid,
  output logic [NUM_CH*USED_W-1:0]   slots_used,
  output logic [NUM_CH-1:0]          err_release
);

  localparam int unsigned OFF_W = $clog2(RING_BYTES);
  localparam int unsigned SUM_W = ((OFF_W > SIZE_W) ? OFF_W : SIZE_W) + 1;

  typedef enum logic {StNeedCfg, StActive} state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [VADDR_W-1:0] RING_BASE =
        VADDR_W'(BASE_VADDR + 64'(c) * 64'(RING_BYTES));

    logic [OFF_W-1:0]  wr_off_q;
    logic [OFF_W:0]    slot_end_q;
    logic [USED_W-1:0] used_q;
    logic              err_q;
    state_e            state_q;

    logic [OFF_W-1:0]   slot_end_wrap;
    logic [SUM_W-1:0]   next_sum;
    logic [VADDR_W-1:0] cur_vaddr;
    logic               new_slot, active, cfg_v, cfg_hs, note_hs, grant, rel_eff;

    // Slot end equal to RING_BYTES folds back to offset 0.
    assign slot_end_wrap = (slot_end_q >= (OFF_W+1)'(RING_BYTES)) ?
                           OFF_W'(slot_end_q - (OFF_W+1)'(RING_BYTES)) : OFF_W'(slot_end_q);
    assign new_slot  = (wr_off_q == slot_end_wrap);
    assign active    = rst_n && (state_q == StActive);
    assign cfg_v     = rst_n && (state_q == StNeedCfg) &&
                       (!new_slot || (used_q < USED_W'(SLOTS)) || release_valid[c]);
    assign cfg_hs    = cfg_v && cfg_ready[c];
    assign note_hs   = active && notify_valid[c] && link_ready[c];
    assign grant     = cfg_hs && new_slot;
    assign rel_eff   = release_valid[c] && (used_q != '0);
    assign next_sum  = SUM_W'(wr_off_q) + SUM_W'(notify_size[c*SIZE_W +: SIZE_W]);
    assign cur_vaddr = RING_BASE + VADDR_W'(wr_off_q);

    assign cfg_valid[c]                   = cfg_v;
    assign cfg_vaddr[c*VADDR_W +: VADDR_W] = rst_n ? cur_vaddr : '0;
    assign cfg_size[c*32 +: 32] = !rst_n  ? 32'd0 :
                                  new_slot ? 32'(ALLOC_BYTES / TRANSFER_SIZE) :
                                  32'((slot_end_q - {1'b0, wr_off_q}) /
                                      (OFF_W+1)'(TRANSFER_SIZE));
    assign notify_ready[c]                  = active && link_ready[c];
    assign link_valid[c]                    = active && notify_valid[c];
    assign link_vaddr[c*VADDR_W +: VADDR_W] = rst_n ? cur_vaddr : '0;
    assign link_size[c*SIZE_W +: SIZE_W]    = rst_n ? notify_size[c*SIZE_W +: SIZE_W] : '0;
    assign link_last[c]                     = rst_n && notify_last[c];
    assign slots_used[c*USED_W +: USED_W]   = rst_n ? used_q : '0;
    assign err_release[c]                   = rst_n && err_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_off_q   <= '0;
        slot_end_q <= '0;
        used_q     <= '0;
        err_q      <= 1'b0;
        state_q    <= StNeedCfg;
      end else begin
        if (grant && !rel_eff) begin
          used_q <= used_q + USED_W'(1);
        end else if (rel_eff && !grant) begin
          used_q <= used_q - USED_W'(1);
        end
        if (release_valid[c] && (used_q == '0)) begin
          err_q <= 1'b1;
        end
        unique case (state_q)
          StNeedCfg: begin
            if (cfg_hs) begin
              if (new_slot) begin
                slot_end_q <= {1'b0, wr_off_q} + (OFF_W+1)'(ALLOC_BYTES);
              end
              state_q <= StActive;
            end
          end
          StActive: begin
            if (note_hs) begin
              // Oversized notifications are clamped at the slot boundary.
              if (next_sum >= SUM_W'(slot_end_q)) begin
                wr_off_q <= slot_end_wrap;
                state_q  <= StNeedCfg;
              end else if (notify_last[c]) begin
                wr_off_q <= LAST_NEW_SLOT ? slot_end_wrap : OFF_W'(next_sum);
                state_q  <= StNeedCfg;
              end else begin
                wr_off_q <= OFF_W'(next_sum);
              end
            end
          end
          default: state_q <= StNeedCfg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_buffer_ring_writer_ctrl.sv
// Bench for stream_buffer_ring_writer_ctrl: two instances (after-last reuse / fresh slot)
// checked every cycle against a byte-offset model, plus directed literal expectations.
module tb_stream_buffer_ring_writer_ctrl;
  localparam int NUM_CH = 4;
  localparam int XFER   = 64;
  localparam int ALLOC  = 65536;
  localparam int RING   = 1048576;
  localparam int SLOTS  = 16;
  localparam int VW     = 48;
  localparam int SW     = 28;
  localparam int UW     = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0]    notify_valid, notify_last, cfg_ready, link_ready, release_valid;
  logic [NUM_CH*SW-1:0] notify_size;

  logic [NUM_CH-1:0]    notify_ready [2];
  logic [NUM_CH-1:0]    cfg_valid    [2];
  logic [NUM_CH-1:0]    link_valid   [2];
  logic [NUM_CH-1:0]    link_last    [2];
  logic [NUM_CH-1:0]    err_release  [2];
  logic [NUM_CH*VW-1:0] cfg_vaddr    [2];
  logic [NUM_CH*VW-1:0] link_vaddr   [2];
  logic [NUM_CH*32-1:0] cfg_size     [2];
  logic [NUM_CH*SW-1:0] link_size    [2];
  logic [NUM_CH*UW-1:0] slots_used   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    stream_buffer_ring_writer_ctrl #(
      .NUM_CH       (NUM_CH),
      .TRANSFER_SIZE(XFER),
      .ALLOC_BYTES  (ALLOC),
      .RING_BYTES   (RING),
      .BASE_VADDR   (0),
      .LAST_NEW_SLOT(m == 1),
      .VADDR_W      (VW),
      .SIZE_W       (SW)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .notify_valid (notify_valid),
      .notify_ready (notify_ready[m]),
      .notify_size  (notify_size),
      .notify_last  (notify_last),
      .cfg_valid    (cfg_valid[m]),
      .cfg_ready    (cfg_ready),
      .cfg_vaddr    (cfg_vaddr[m]),
      .cfg_size     (cfg_size[m]),
      .link_valid   (link_valid[m]),
      .link_ready   (link_ready),
      .link_vaddr   (link_vaddr[m]),
      .link_size    (link_size[m]),
      .link_last    (link_last[m]),
      .release_valid(release_valid),
      .slots_used   (slots_used[m]),
      .err_release  (err_release[m])
    );
  end

  // Model state: byte offset in ring, end of the current slot, slots held, writer active.
  int m_off  [2][NUM_CH];
  int m_end  [2][NUM_CH];
  int m_used [2][NUM_CH];
  bit m_act  [2][NUM_CH];
  bit m_err  [2][NUM_CH];

  task automatic cmp(input string name, input int m, input int c,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d ch%0d: got 0x%0h want 0x%0h", name, m, c, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int left, n, sz;
        bit rel, ecv, elv, grant;
        longint base;
        base = longint'(c) * RING;
        left = ((m_end[m][c] - m_off[m][c]) % RING + RING) % RING;
        rel  = release_valid[c];
        sz   = int'(notify_size[c*SW +: SW]);
        ecv  = rst_n && !m_act[m][c] && (left != 0 || m_used[m][c] < SLOTS || rel);
        elv  = rst_n && m_act[m][c] && notify_valid[c];

        cmp("cfg_valid", m, c, 64'(cfg_valid[m][c]), 64'(ecv));
        cmp("link_valid", m, c, 64'(link_valid[m][c]), 64'(elv));
        cmp("notify_ready", m, c, 64'(notify_ready[m][c]),
            64'(rst_n && m_act[m][c] && link_ready[c]));
        cmp("slots_used", m, c, 64'(slots_used[m][c*UW +: UW]),
            rst_n ? 64'(m_used[m][c]) : 64'd0);
        cmp("err_release", m, c, 64'(err_release[m][c]), 64'(rst_n && m_err[m][c]));
        if (ecv) begin
          cmp("cfg_vaddr", m, c, 64'(cfg_vaddr[m][c*VW +: VW]), 64'(base + m_off[m][c]));
          cmp("cfg_size", m, c, 64'(cfg_size[m][c*32 +: 32]),
              64'((left == 0) ? ALLOC / XFER : left / XFER));
        end
        if (elv) begin
          cmp("link_vaddr", m, c, 64'(link_vaddr[m][c*VW +: VW]), 64'(base + m_off[m][c]));
          cmp("link_size", m, c, 64'(link_size[m][c*SW +: SW]), 64'(sz));
          cmp("link_last", m, c, 64'(link_last[m][c]), 64'(notify_last[c]));
        end
        if (!rst_n) begin
          cmp("rst_cfg_vaddr", m, c, 64'(cfg_vaddr[m][c*VW +: VW]), 64'd0);
          cmp("rst_link_vaddr", m, c, 64'(link_vaddr[m][c*VW +: VW]), 64'd0);
          m_off[m][c]  = 0;
          m_end[m][c]  = 0;
          m_used[m][c] = 0;
          m_act[m][c]  = 1'b0;
          m_err[m][c]  = 1'b0;
        end else begin
          grant = ecv && cfg_ready[c] && left == 0;
          if (ecv && cfg_ready[c]) begin
            if (left == 0) m_end[m][c] = m_off[m][c] + ALLOC;
            m_act[m][c] = 1'b1;
          end else if (elv && link_ready[c]) begin
            n = m_off[m][c] + sz;
            if (n >= m_end[m][c]) begin
              m_off[m][c] = m_end[m][c] % RING;
              m_act[m][c] = 1'b0;
            end else if (notify_last[c]) begin
              m_off[m][c] = (m == 1) ? m_end[m][c] % RING : n;
              m_act[m][c] = 1'b0;
            end else begin
              m_off[m][c] = n;
            end
          end
          if (rel && m_used[m][c] == 0) m_err[m][c] = 1'b1;
          m_used[m][c] = m_used[m][c] + (grant ? 1 : 0) - ((rel && m_used[m][c] > 0) ? 1 : 0);
        end
      end
    end
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #6;
  endtask

  task automatic idle_inputs();
    notify_valid  = '0;
    notify_last   = '0;
    notify_size   = '0;
    cfg_ready     = '0;
    link_ready    = '0;
    release_valid = '0;
  endtask

  task automatic set_note(input int c, input bit v, input int size, input bit last);
    notify_valid[c]          = v;
    notify_size[c*SW +: SW]  = SW'(size);
    notify_last[c]           = last;
    link_ready[c]            = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) advance();
    settle();
    lit("reset_cfg_valid", 64'(cfg_valid[0]), 64'd0);
    lit("reset_slots_used", 64'(slots_used[0]), 64'd0);
    advance();

    // First slot on every channel offered after reset.
    rst_n = 1'b1;
    cfg_ready[0] = 1'b1;
    settle();
    lit("first_cfg_valid", 64'(cfg_valid[0]), 64'hf);
    lit("first_cfg_vaddr_ch0", 64'(cfg_vaddr[0][0 +: VW]), 64'h0);
    lit("first_cfg_size_ch0", 64'(cfg_size[0][0 +: 32]), 64'd1024);
    lit("first_cfg_vaddr_ch3", 64'(cfg_vaddr[0][3*VW +: VW]), 64'h300000);
    advance();
    cfg_ready[0] = 1'b0;
    settle();
    lit("used_after_grant", 64'(slots_used[0][0 +: UW]), 64'd1);
    advance();

    // Sixteen 4 KiB writes fill slot 0.
    set_note(0, 1'b1, 4096, 1'b0);
    for (int k = 0; k < 16; k++) begin
      settle();
      if (k == 0) lit("link_vaddr_k0", 64'(link_vaddr[0][0 +: VW]), 64'h0);
      if (k == 15) lit("link_vaddr_k15", 64'(link_vaddr[1][0 +: VW]), 64'hf000);
      advance();
    end
    set_note(0, 1'b0, 0, 1'b0);
    cfg_ready[0] = 1'b1;
    settle();
    lit("slot1_cfg_valid", 64'(cfg_valid[0][0]), 64'd1);
    lit("slot1_cfg_vaddr", 64'(cfg_vaddr[0][0 +: VW]), 64'h10000);
    advance();
    cfg_ready[0] = 1'b0;
    settle();
    lit("used_two", 64'(slots_used[0][0 +: UW]), 64'd2);
    advance();

    // Fill the remaining slots with whole-slot writes.
    for (int i = 0; i < 14; i++) begin
      set_note(0, 1'b1, ALLOC, 1'b0);
      advance();
      set_note(0, 1'b0, 0, 1'b0);
      cfg_ready[0] = 1'b1;
      advance();
      cfg_ready[0] = 1'b0;
    end
    settle();
    lit("used_full", 64'(slots_used[0][0 +: UW]), 64'd16);
    advance();
    set_note(0, 1'b1, ALLOC, 1'b0);
    advance();

    // Ring full: offer held back while notifies keep arriving.
    cfg_ready[0] = 1'b1;
    set_note(0, 1'b1, 4096, 1'b0);
    for (int k = 0; k < 100; k++) begin
      settle();
      if (k == 0 || k == 99) begin
        lit("full_cfg_valid", 64'(cfg_valid[0][0]), 64'd0);
        lit("full_notify_ready", 64'(notify_ready[0][0]), 64'd0);
      end
      advance();
    end
    release_valid[0] = 1'b1;
    settle();
    lit("release_cfg_valid", 64'(cfg_valid[0][0]), 64'd1);
    lit("release_cfg_vaddr", 64'(cfg_vaddr[0][0 +: VW]), 64'h0);
    advance();
    release_valid[0] = 1'b0;
    cfg_ready[0]     = 1'b0;
    set_note(0, 1'b0, 0, 1'b0);
    settle();
    lit("used_after_swap", 64'(slots_used[0][0 +: UW]), 64'd16);
    advance();

    // End-of-stream on ch1: remainder (dut0) vs fresh slot (dut1).
    cfg_ready[1] = 1'b1;
    advance();
    cfg_ready[1] = 1'b0;
    set_note(1, 1'b1, 4096, 1'b1);
    advance();
    set_note(1, 1'b0, 0, 1'b0);
    settle();
    lit("rem_cfg_vaddr", 64'(cfg_vaddr[0][1*VW +: VW]), 64'h101000);
    lit("rem_cfg_size", 64'(cfg_size[0][1*32 +: 32]), 64'd960);
    lit("fresh_cfg_vaddr", 64'(cfg_vaddr[1][1*VW +: VW]), 64'h110000);
    lit("fresh_cfg_size", 64'(cfg_size[1][1*32 +: 32]), 64'd1024);
    advance();
    cfg_ready[1] = 1'b1;
    advance();
    cfg_ready[1] = 1'b0;
    settle();
    lit("rem_used", 64'(slots_used[0][1*UW +: UW]), 64'd1);
    lit("fresh_used", 64'(slots_used[1][1*UW +: UW]), 64'd2);
    advance();

    // Consumer back-pressure on ch1, then ch3 brought up.
    notify_valid[1]            = 1'b1;
    notify_size[1*SW +: SW]    = SW'(2048);
    cfg_ready[3]               = 1'b1;
    repeat (3) begin
      settle();
      lit("bp_notify_ready", 64'(notify_ready[0][1]), 64'd0);
      lit("bp_link_vaddr", 64'(link_vaddr[0][1*VW +: VW]), 64'h101000);
      advance();
      cfg_ready[3] = 1'b0;
    end
    notify_valid[1] = 1'b0;

    // Concurrent traffic on ch0 and ch3.
    set_note(0, 1'b1, 4096, 1'b0);
    set_note(3, 1'b1, 4096, 1'b0);
    settle();
    lit("ch3_link_vaddr0", 64'(link_vaddr[0][3*VW +: VW]), 64'h300000);
    lit("ch0_link_vaddr0", 64'(link_vaddr[0][0 +: VW]), 64'h0);
    advance();
    settle();
    lit("ch3_link_vaddr1", 64'(link_vaddr[1][3*VW +: VW]), 64'h301000);
    lit("ch0_link_vaddr1", 64'(link_vaddr[1][0 +: VW]), 64'h1000);
    advance();
    set_note(0, 1'b0, 0, 1'b0);
    set_note(3, 1'b0, 0, 1'b0);

    // Spurious release on an empty channel.
    release_valid[2] = 1'b1;
    advance();
    release_valid[2] = 1'b0;
    settle();
    lit("err_release_ch2", 64'(err_release[0][2]), 64'd1);
    lit("err_used_ch2", 64'(slots_used[0][2*UW +: UW]), 64'd0);
    lit("err_release_ch0", 64'(err_release[0][0]), 64'd0);
    advance();

    // Reset mid-stream.
    set_note(0, 1'b1, 4096, 1'b0);
    rst_n = 1'b0;
    settle();
    lit("mid_rst_cfg_valid", 64'(cfg_valid[0]), 64'd0);
    lit("mid_rst_link_valid", 64'(link_valid[0]), 64'd0);
    lit("mid_rst_notify_ready", 64'(notify_ready[1]), 64'd0);
    lit("mid_rst_slots_used", 64'(slots_used[0]), 64'd0);
    advance();
    advance();
    rst_n = 1'b1;
    set_note(0, 1'b0, 0, 1'b0);
    settle();
    lit("post_rst_cfg_valid", 64'(cfg_valid[0]), 64'hf);
    lit("post_rst_cfg_vaddr_ch0", 64'(cfg_vaddr[0][0 +: VW]), 64'h0);
    lit("post_rst_cfg_vaddr_ch3", 64'(cfg_vaddr[1][3*VW +: VW]), 64'h300000);
    lit("post_rst_err", 64'(err_release[0]), 64'd0);
    advance();
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
